// File: rtl/fetch_seq_if.sv
// fetch_seq_if: instruction-memory req/ack bus plus the execute-stage valid/ready handoff.
interface fetch_seq_if #(parameter int W = 15, parameter int IW = 16);
  logic imem_req;
  logic [W-1:0] imem_addr;
  logic imem_ack;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instr;
  logic instr_valid;
  logic instr_ready;
  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input imem_ack, imem_rdata, instr_ready
  );
  modport slave (
    input imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: fetch/execute/update sequencer driving the pcount controls with Hack jump evaluation.
module fetch_seq #(
  parameter int W = 15,
  parameter int IW = 16
) (
  input  logic         clk50m,
  input  logic         rst,
  input  logic         run,
  input  logic [W-1:0] pc,
  output logic         pc_en,
  output logic         pc_load,
  output logic         pc_inc,
  output logic [W-1:0] pc_target,
  fetch_seq_if.master  bus,
  input  logic         zr,
  input  logic         ng,
  input  logic [W-1:0] a_reg
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, UPDATE} state_t;
  state_t state;
  logic taken;
  assign taken = bus.instr[IW-1] & ((bus.instr[2] & ng) | (bus.instr[1] & zr) | (bus.instr[0] & ~ng & ~zr));
  // pc is passed straight through so the first FETCH cycle sees the counter's post-UPDATE value
  assign bus.imem_addr = bus.imem_req ? pc : '0;
  always_ff @(posedge clk50m) begin
    if (rst) begin
      state <= IDLE;
      bus.imem_req <= 1'b0;
      bus.instr <= '0;
      bus.instr_valid <= 1'b0;
      pc_en <= 1'b0;
      pc_load <= 1'b0;
      pc_inc <= 1'b0;
      pc_target <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= run ? FETCH : IDLE;
          bus.imem_req <= run;
        end
        FETCH: if (bus.imem_ack) begin
          state <= EXEC;
          bus.imem_req <= 1'b0;
          bus.instr <= bus.imem_rdata;
          bus.instr_valid <= 1'b1;
        end
        EXEC: if (bus.instr_ready) begin
          state <= UPDATE;
          bus.instr_valid <= 1'b0;
          pc_en <= 1'b1;
          pc_load <= taken;
          pc_inc <= ~taken;
          pc_target <= taken ? a_reg : '0;
        end
        UPDATE: begin
          state <= run ? FETCH : IDLE;
          bus.imem_req <= run;
          pc_en <= 1'b0;
          pc_load <= 1'b0;
          pc_inc <= 1'b0;
          pc_target <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed and randomized fetch sequences checked against a per-instruction reference model.
module tb_fetch_seq;
  logic clk50m = 1'b0;
  logic rst, run, pc_en, pc_load, pc_inc, zr, ng;
  logic [14:0] cnt, pc_target, a_reg, model_pc;
  int n_chk = 0;
  int n_fail = 0;

  fetch_seq_if #(.W(15), .IW(16)) bus();

  fetch_seq #(.W(15), .IW(16)) dut (
    .clk50m(clk50m), .rst(rst), .run(run), .pc(cnt),
    .pc_en(pc_en), .pc_load(pc_load), .pc_inc(pc_inc), .pc_target(pc_target),
    .bus(bus), .zr(zr), .ng(ng), .a_reg(a_reg)
  );

  always #10 clk50m = ~clk50m;

  // attached program counter
  always @(posedge clk50m)
    if (rst) cnt <= '0;
    else if (pc_en) cnt <= pc_load ? pc_target : (pc_inc ? cnt + 15'd1 : cnt);

  task automatic tick;
    @(posedge clk50m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_instr(input logic [15:0] ins, input int al, input int rl,
                          input logic z, input logic n, input logic [14:0] a, input logic run_after);
    logic tk;
    int k;
    k = 0;
    while (bus.imem_req !== 1'b1 && k < 20) begin
      tick;
      k++;
    end
    chk("req_seen", 32'(bus.imem_req), 1);
    chk("fetch_addr", 32'(bus.imem_addr), 32'(model_pc));
    for (int i = 0; i < al; i++) begin
      tick;
      chk("req_hold", 32'(bus.imem_req), 1);
      chk("addr_hold", 32'(bus.imem_addr), 32'(model_pc));
      chk("valid_wait", 32'(bus.instr_valid), 0);
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = ins;
    tick;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 16'($urandom);
    chk("valid_rise", 32'(bus.instr_valid), 1);
    chk("instr", 32'(bus.instr), 32'(ins));
    chk("req_drop", 32'(bus.imem_req), 0);
    for (int i = 0; i < rl; i++) begin
      tick;
      chk("instr_hold", 32'(bus.instr), 32'(ins));
      chk("valid_hold", 32'(bus.instr_valid), 1);
      chk("no_pc_en", 32'(pc_en), 0);
    end
    // a C-instruction jumps when the ALU result class (<0, =0, >0) is selected by j1/j2/j3
    tk = ins[15] && ((ins[2] && n) || (ins[1] && z) || (ins[0] && !n && !z));
    bus.instr_ready = 1'b1;
    zr = z;
    ng = n;
    a_reg = a;
    run = run_after;
    tick;
    bus.instr_ready = 1'b0;
    zr = 1'($urandom);
    ng = 1'($urandom);
    a_reg = 15'($urandom);
    chk("upd_en", 32'(pc_en), 1);
    chk("upd_load", 32'(pc_load), 32'(tk));
    chk("upd_inc", 32'(pc_inc), 32'(!tk));
    chk("upd_target", 32'(pc_target), tk ? 32'(a) : 0);
    chk("valid_fall", 32'(bus.instr_valid), 0);
    model_pc = tk ? a : model_pc + 15'd1;
    tick;
    chk("en_fall", 32'(pc_en), 0);
    chk("pc_cnt", 32'(cnt), 32'(model_pc));
    chk("next_req", 32'(bus.imem_req), 32'(run_after));
    if (run_after) chk("next_addr", 32'(bus.imem_addr), 32'(model_pc));
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    zr = 1'b0;
    ng = 1'b0;
    a_reg = '0;
    model_pc = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_req", 32'(bus.imem_req), 0);
      chk("rst_addr", 32'(bus.imem_addr), 0);
      chk("rst_valid", 32'(bus.instr_valid), 0);
      chk("rst_instr", 32'(bus.instr), 0);
      chk("rst_pc", 32'({pc_en, pc_load, pc_inc}), 0);
      chk("rst_target", 32'(pc_target), 0);
    end
    rst = 1'b0;
    chk("idle_req", 32'(bus.imem_req), 0);
    tick;
    chk("first_req", 32'(bus.imem_req), 1);
    chk("first_addr", 32'(bus.imem_addr), 0);
    do_instr(16'h0005, 0, 0, 1'b0, 1'b0, 15'h0000, 1'b1);
    do_instr(16'h0006, 0, 0, 1'b1, 1'b0, 15'h0040, 1'b1);
    do_instr(16'h0007, 0, 0, 1'b0, 1'b1, 15'h0040, 1'b1);
    do_instr(16'hE007, 0, 0, 1'b0, 1'b0, 15'h001E, 1'b1);
    do_instr(16'hE002, 0, 0, 1'b0, 1'b0, 15'h0200, 1'b1);
    do_instr(16'hE002, 0, 0, 1'b1, 1'b0, 15'h0100, 1'b1);
    do_instr(16'hE001, 2, 4, 1'b0, 1'b0, 15'h7FFF, 1'b1);
    do_instr(16'hE000, 0, 0, 1'b1, 1'b1, 15'h1234, 1'b1);
    for (int i = 0; i < 30; i++)
      do_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 15'($urandom), 1'b1);
    do_instr(16'hE004, 1, 1, 1'b0, 1'b1, 15'h0055, 1'b0);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stop_req", 32'(bus.imem_req), 0);
      chk("stop_en", 32'(pc_en), 0);
      chk("stop_valid", 32'(bus.instr_valid), 0);
    end
    bus.imem_ack = 1'b0;
    run = 1'b1;
    tick;
    chk("restart_req", 32'(bus.imem_req), 1);
    chk("restart_addr", 32'(bus.imem_addr), 32'(model_pc));
    tick;
    rst = 1'b1;
    tick;
    chk("mid_rst_req", 32'(bus.imem_req), 0);
    chk("mid_rst_en", 32'(pc_en), 0);
    rst = 1'b0;
    run = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'hFFFF;
    tick;
    bus.imem_ack = 1'b0;
    chk("late_ack_valid", 32'(bus.instr_valid), 0);
    chk("late_ack_instr", 32'(bus.instr), 0);
    chk("late_ack_req", 32'(bus.imem_req), 0);
    model_pc = '0;
    chk("rst_cnt", 32'(cnt), 0);
    run = 1'b1;
    do_instr(16'hEC07, 0, 2, 1'b1, 1'b0, 15'h0ABC, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer that sits directly upstream of the program counter `pcount`. It drives the counter's `en`/`load`/`inc`/`cnt_in` controls and uses the counter's `cnt` output as the fetch address. It runs a req/ack handshake to instruction memory, holds the fetched word for the execute stage under a valid/ready handshake, and evaluates Hack-style jump conditions to choose between loading a branch target and incrementing the counter.

## Interface
Parameters:
- `W`, 15: program-counter / instruction-address width.
- `IW`, 16: instruction width. Bit IW-1 is the C-instruction flag; bits 2:0 are j1 j2 j3.

Ports:
- `clk50m`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  enables fetching; sampled in IDLE and UPDATE.
- `pc`  in  W  current counter value (`pcount.cnt`).
- `pc_en`  out  1  to `pcount.en`.
- `pc_load`  out  1  to `pcount.load`.
- `pc_inc`  out  1  to `pcount.inc`.
- `pc_target`  out  W  to `pcount.cnt_in`; jump target.
- `imem_req`  out  1  instruction-memory request, held until ack.
- `imem_addr`  out  W  fetch address.
- `imem_ack`  in  1  memory response strobe; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  IW  fetched instruction.
- `instr`  out  IW  registered instruction to the execute stage.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  execute stage accepts the instruction.
- `zr`, `ng`  in  1 each  ALU zero and negative flags, valid in the accept cycle.
- `a_reg`  in  W  jump target from the A register, valid in the accept cycle.

## Operation
- FSM states: IDLE, FETCH, EXEC, UPDATE. Reset state is IDLE.
- IDLE: if `run`=1, go to FETCH next cycle; otherwise stay in IDLE.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc` for the whole state.
  - On `imem_ack`=1 (the first FETCH cycle counts), capture `imem_rdata` into `instr` and go to EXEC.
  - Without ack, remain in FETCH.
- EXEC:
  - `instr_valid`=1 and `instr` is held stable.
  - When `instr_valid` and `instr_ready` are both 1, sample `zr`, `ng`, `a_reg`, compute `taken`, register `taken` and `a_reg`, and go to UPDATE.
- Jump rule: `taken` = `instr[IW-1]` & ((j1 & `ng`) | (j2 & `zr`) | (j3 & ~`ng` & ~`zr`)).
  - An A-instruction (bit IW-1 = 0) never jumps.
  - j = 3'b111 is an unconditional jump.
- UPDATE lasts exactly one cycle.
  - `pc_en`=1 in this cycle.
  - If taken: `pc_load`=1 and `pc_target` = registered `a_reg`.
  - If not taken: `pc_inc`=1.
  - Next state is FETCH if `run`=1, else IDLE.
- Output rules:
  - `pc_en`/`pc_load`/`pc_inc` are 0 outside UPDATE.
  - `pc_load` and `pc_inc` are never high together.
  - `pc_target` is 0 when not loading.
- Address wrap (2^W-1 -> 0) is handled by `pcount`. This block passes `pc` through unmodified.
- `imem_ack` outside FETCH is ignored.
- `instr_ready` outside EXEC is ignored.

## Timing
- Reset values: all outputs 0, `instr`=0, state IDLE.
- Reset is applied at the next rising edge regardless of state, which covers reset mid-operation:
  - `imem_req` drops.
  - A pending or late `imem_ack` is discarded.
  - No `pc_*` pulse is issued.
- Minimum instruction period is 3 cycles: FETCH (ack in the same cycle), EXEC (ready in the same cycle), UPDATE.
- Each memory wait cycle adds 1 cycle; each cycle with `instr_ready` low adds 1 cycle.
- `pcount` updates on the edge that ends UPDATE, so the following FETCH presents the new `pc` on `imem_addr` in its first cycle.
- `instr_valid` rises on the cycle after ack. It falls on the cycle after the accept.
- `run` deasserted mid-instruction: the current instruction completes through UPDATE, then the FSM enters IDLE. No new `imem_req` is issued.
- Simultaneous `rst` and `imem_ack`: reset wins.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `run`=1, then release.
  - During reset: all outputs stay 0.
  - First `imem_req` appears on the 2nd cycle after release, with `imem_addr`=0 (pcount at 0).
- Sequential fetch: with `pcount` attached, feed A-instructions 16'h0005, 16'h0006, 16'h0007 with ack latency 0.
  - Fetch addresses are 0, 1, 2.
  - One `pc_inc` pulse per instruction.
  - Period is exactly 3 cycles.
- Unconditional jump: instr 16'hE007 with `a_reg`=15'h001E.
  - UPDATE shows `pc_load`=1 and `pc_target`=15'h001E.
  - Next `imem_addr`=15'h001E.
- Conditional JEQ: instr 16'hE002.
  - With `zr`=0: `pc_inc`, next address is pc+1.
  - Repeat with `zr`=1, `a_reg`=15'h0100: `pc_load`, next address is 15'h0100.
- Backpressure and memory latency:
  - Ack delayed 2 cycles: `imem_req` and `imem_addr` held stable, `instr_valid` follows 1 cycle after ack.
  - `instr_ready` low 4 cycles: `instr` stable and no `pc_*` pulse until ready.
- Reset and stop:
  - `rst` pulsed while in FETCH awaiting ack: `imem_req`=0 next cycle, a late ack is ignored, the FSM is in IDLE.
  - `run` dropped during EXEC: one UPDATE pulse, then IDLE with no further requests.
